// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch-side PC sequencer.
// Issues fetch addresses under a req/ready handshake. It honours MIPS delay
// slots, so the slot at branch_pc+4 is always fetched before the target.
// It also applies exception redirects and marks accepted wrong-path fetches
// with if_flush.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_ds_fetched,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        if_req,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        if_flush,
    output logic        redirect_busy
);

    // SEQ: sequential fetch.
    // DS_WAIT: target latched, delay slot not yet accepted.
    // TGT_PEND: target latched, a wrong-path request is still in flight.
    typedef enum logic [1:0] {
        SEQ      = 2'd0,
        DS_WAIT  = 2'd1,
        TGT_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        hold_q, hold_d;
    logic        run_q, run_d;

    logic accept;
    logic outstanding;
    logic br_redirect;

    // A raised request is held until accepted; stall only blocks new ones.
    assign if_req        = run_q & (hold_q | ~stall);
    assign accept        = if_req & if_ready;
    assign outstanding   = if_req & ~if_ready;
    assign if_pc         = pc_q;
    assign redirect_busy = (state_q != SEQ);
    assign br_redirect   = br_valid & br_taken;

    // Next-state, next-PC and flush decode; exceptions override branches.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        hold_d   = outstanding;
        run_d    = 1'b1;
        if_flush = 1'b0;

        if (exc_valid) begin
            if (outstanding) begin
                // Unaccepted request cannot be retargeted; let it go and flush it.
                tgt_d   = exc_target;
                state_d = TGT_PEND;
            end else begin
                pc_d     = exc_target;
                state_d  = SEQ;
                if_flush = accept;
            end
        end else begin
            unique case (state_q)
                SEQ: begin
                    if (br_redirect) begin
                        if (br_ds_fetched) begin
                            // Slot already in hand: anything accepted now is wrong-path.
                            if (accept) begin
                                pc_d     = br_target;
                                if_flush = 1'b1;
                            end else if (outstanding) begin
                                tgt_d   = br_target;
                                state_d = TGT_PEND;
                            end else begin
                                pc_d = br_target;
                            end
                        end else begin
                            // The fetch accepted this cycle is the delay slot itself.
                            if (accept) begin
                                pc_d = br_target;
                            end else begin
                                tgt_d   = br_target;
                                state_d = DS_WAIT;
                            end
                        end
                    end else if (accept) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                DS_WAIT: begin
                    if (accept) begin
                        pc_d    = tgt_q;
                        state_d = SEQ;
                    end
                end
                TGT_PEND: begin
                    if (accept) begin
                        if_flush = 1'b1;
                        pc_d     = tgt_q;
                        state_d  = SEQ;
                    end
                end
                default: state_d = SEQ;
            endcase
        end
    end

    // State registers; reset discards any redirect in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SEQ;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            hold_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with hand-computed expectations.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_ds_fetched;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        if_flush;
    logic        redirect_busy;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_redirect_ctrl #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .br_ds_fetched(br_ds_fetched),
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .if_req       (if_req),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .if_flush     (if_flush),
        .redirect_busy(redirect_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br_set(input logic [31:0] tgt, input logic ds);
        chk("br_only_in_seq", {31'd0, redirect_busy}, 32'd0);
        br_valid      = 1'b1;
        br_taken      = 1'b1;
        br_target     = tgt;
        br_ds_fetched = ds;
    endtask

    task automatic br_clr();
        br_valid      = 1'b0;
        br_taken      = 1'b0;
        br_ds_fetched = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; if_ready = 1'b1;
        br_valid = 1'b0; br_taken = 1'b0; br_target = 32'd0; br_ds_fetched = 1'b0;
        exc_valid = 1'b0; exc_target = 32'd0;

        // 1. reset and sequential fetch
        step(); step();
        chk("rst_req",   {31'd0, if_req}, 32'd0);
        chk("rst_pc",    if_pc, RPC);
        chk("rst_flush", {31'd0, if_flush}, 32'd0);
        chk("rst_busy",  {31'd0, redirect_busy}, 32'd0);
        resetn = 1'b1;
        #1;
        chk("pre_run_req", {31'd0, if_req}, 32'd0);
        step();
        chk("seq0_req", {31'd0, if_req}, 32'd1);
        chk("seq0_pc",  if_pc, RPC);
        step();
        chk("seq1_pc",  if_pc, RPC + 32'd4);
        step();
        chk("seq2_pc",  if_pc, RPC + 32'd8);

        // 2. taken, slot fetched, port idle -> target next cycle
        stall = 1'b1;
        br_set(32'h8000_0100, 1'b1);
        #1;
        chk("t2_idle_req", {31'd0, if_req}, 32'd0);
        chk("t2_flush",    {31'd0, if_flush}, 32'd0);
        step();
        br_clr(); stall = 1'b0;
        #1;
        chk("t2_pc",    if_pc, 32'h8000_0100);
        chk("t2_req",   {31'd0, if_req}, 32'd1);
        step();
        chk("t2_seq",   if_pc, 32'h8000_0104);

        // 3. taken, slot not yet fetched, slot held by if_ready=0
        stall = 1'b1;
        br_set(32'h0000_1000, 1'b1);
        step();
        br_clr(); stall = 1'b0;
        step();
        chk("t3_pc_slot", if_pc, 32'h0000_1004);
        if_ready = 1'b0;
        br_set(32'h0000_2000, 1'b0);
        #1;
        chk("t3_flush0", {31'd0, if_flush}, 32'd0);
        step();
        br_clr();
        #1;
        chk("t3_busy",   {31'd0, redirect_busy}, 32'd1);
        chk("t3_hold",   if_pc, 32'h0000_1004);
        step();
        chk("t3_hold2",  if_pc, 32'h0000_1004);
        chk("t3_req2",   {31'd0, if_req}, 32'd1);
        if_ready = 1'b1;
        #1;
        chk("t3_slot_flush", {31'd0, if_flush}, 32'd0);
        step();
        chk("t3_tgt",   if_pc, 32'h0000_2000);
        chk("t3_idle",  {31'd0, redirect_busy}, 32'd0);

        // 4. taken, slot fetched, wrong-path 0x1008 outstanding
        stall = 1'b1;
        br_set(32'h0000_1008, 1'b1);
        step();
        br_clr(); stall = 1'b0; if_ready = 1'b0;
        #1;
        br_set(32'h0000_3000, 1'b1);
        #1;
        chk("t4_flush_out", {31'd0, if_flush}, 32'd0);
        step();
        br_clr(); if_ready = 1'b1;
        #1;
        chk("t4_busy",  {31'd0, redirect_busy}, 32'd1);
        chk("t4_pc",    if_pc, 32'h0000_1008);
        chk("t4_flush", {31'd0, if_flush}, 32'd1);
        step();
        chk("t4_tgt",   if_pc, 32'h0000_3000);
        chk("t4_nofl",  {31'd0, if_flush}, 32'd0);

        // 5. exception beats same-cycle branch
        exc_valid = 1'b1; exc_target = 32'hbfc0_0380;
        br_set(32'h0000_4000, 1'b1);
        #1;
        chk("t5_flush", {31'd0, if_flush}, 32'd1);
        step();
        exc_valid = 1'b0; br_clr();
        #1;
        chk("t5_pc",    if_pc, 32'hbfc0_0380);
        chk("t5_busy",  {31'd0, redirect_busy}, 32'd0);
        // exception with an outstanding request
        if_ready = 1'b0; exc_valid = 1'b1; exc_target = 32'h0000_5000;
        step();
        exc_valid = 1'b0;
        #1;
        chk("t5b_busy", {31'd0, redirect_busy}, 32'd1);
        chk("t5b_pc",   if_pc, 32'hbfc0_0380);
        if_ready = 1'b1;
        #1;
        chk("t5b_flush", {31'd0, if_flush}, 32'd1);
        step();
        chk("t5b_tgt",  if_pc, 32'h0000_5000);

        // not-taken branch: plain increment
        br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h0000_9990;
        #1;
        chk("nt_flush", {31'd0, if_flush}, 32'd0);
        step();
        br_clr();
        #1;
        chk("nt_pc",    if_pc, 32'h0000_5004);
        // taken, slot accepted this cycle
        br_set(32'h0000_6000, 1'b0);
        #1;
        chk("ds_acc_flush", {31'd0, if_flush}, 32'd0);
        step();
        br_clr();
        #1;
        chk("ds_acc_pc",   if_pc, 32'h0000_6000);
        chk("ds_acc_busy", {31'd0, redirect_busy}, 32'd0);

        // 6. hold under toggling stall, then wrap
        stall = 1'b1;
        br_set(32'hffff_fffc, 1'b1);
        step();
        br_clr(); stall = 1'b0; if_ready = 1'b0;
        #1;
        chk("t6_req0", {31'd0, if_req}, 32'd1);
        step();
        stall = 1'b1;
        #1;
        chk("t6_req1", {31'd0, if_req}, 32'd1);
        chk("t6_pc1",  if_pc, 32'hffff_fffc);
        step();
        stall = 1'b0;
        #1;
        chk("t6_pc2",  if_pc, 32'hffff_fffc);
        step();
        stall = 1'b1; if_ready = 1'b1;
        #1;
        chk("t6_req3", {31'd0, if_req}, 32'd1);
        step();
        chk("t6_wrap",  if_pc, 32'h0000_0000);
        chk("t6_nohold", {31'd0, if_req}, 32'd0);

        // reset mid-operation
        stall = 1'b0;
        step(); step();
        resetn = 1'b0;
        #1;
        chk("mr_req", {31'd0, if_req}, 32'd0);
        chk("mr_pc",  if_pc, RPC);
        step();
        resetn = 1'b1;
        step();
        chk("mr_run_pc", if_pc, RPC);
        chk("mr_run_req", {31'd0, if_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
